// File: rtl/rat_pkg.sv
// Shared RAT CPU constants and the stack-operation encoding used by the
// control unit and the return-address stack.
package rat_pkg;

    localparam int unsigned RAT_ADDR_W = 8;
    localparam int unsigned RAS_DEPTH  = 8;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/ras_regfile.sv
// Return-address storage: DEPTH x N registers, one synchronous write port and
// one asynchronous read port; contents are deliberately not reset.
module ras_regfile #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem_q [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack: pointer and sticky error flags around ras_regfile.
// Top of stack is read combinationally so the PC can load it on the popping edge.
module ret_addr_stack
    import rat_pkg::*;
#(
    parameter int unsigned n     = RAT_ADDR_W,
    parameter int unsigned DEPTH = RAS_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CLR,
    input  logic                     PUSH,
    input  logic                     POP,
    input  logic [n-1:0]             DIN,
    output logic [n-1:0]             DOUT,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     OVF,
    output logic                     UNF
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] sp_q, sp_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic [AW-1:0] raddr_s;
    logic [n-1:0]  rdata_s;
    logic          empty_s;
    logic          full_s;
    stack_op_e     op_s;

    assign empty_s = (sp_q == '0);
    assign full_s  = (sp_q == DEPTH_C);
    assign raddr_s = sp_q[AW-1:0] - AW'(1);

    // Next pointer, flags and write-port control from the strobes.
    always_comb begin
        op_s    = decode_op(PUSH, POP);
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we_s    = 1'b0;
        waddr_s = sp_q[AW-1:0];
        if (CLR) begin
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            case (op_s)
                OP_PUSH: begin
                    if (full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        we_s = 1'b1;
                        sp_d = sp_q + CW'(1);
                    end
                end
                OP_POP: begin
                    if (empty_s) begin
                        unf_d = 1'b1;
                    end else begin
                        sp_d = sp_q - CW'(1);
                    end
                end
                OP_REPL: begin
                    // Replace on an empty stack degrades to a push into slot 0.
                    we_s = 1'b1;
                    if (empty_s) begin
                        sp_d  = CW'(1);
                        unf_d = 1'b1;
                    end else begin
                        waddr_s = raddr_s;
                    end
                end
                default: begin
                    sp_d = sp_q;
                end
            endcase
        end
    end

    // Pointer and sticky flag registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ras_regfile #(
        .N     (n),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (CLK),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (DIN),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    assign DOUT  = empty_s ? '0 : rdata_s;
    assign COUNT = sp_q;
    assign EMPTY = empty_s;
    assign FULL  = full_s;
    assign OVF   = ovf_q;
    assign UNF   = unf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Randomised scoreboard bench for ret_addr_stack (n=8, DEPTH=4) with a
// queue-based reference model and directed scenarios.
module tb_ret_addr_stack;

    typedef struct packed {
        logic [7:0] dout;
        logic [2:0] count;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, push, pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] count;
    logic       empty, full, ovf, unf;

    int tests  = 0;
    int errors = 0;

    obs_t       exp_q[$];
    string      name_q[$];
    logic [7:0] model[$];
    logic       m_ovf, m_unf;

    ret_addr_stack #(.n(8), .DEPTH(4)) dut (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .PUSH(push), .POP(pop),
        .DIN(din), .DOUT(dout), .COUNT(count), .EMPTY(empty), .FULL(full),
        .OVF(ovf), .UNF(unf)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_obs();
        obs_t o;
        o.count = 3'(model.size());
        o.empty = (model.size() == 0);
        o.full  = (model.size() == 4);
        o.dout  = (model.size() == 0) ? 8'h00 : model[model.size()-1];
        o.ovf   = m_ovf;
        o.unf   = m_unf;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.dout = dout; o.count = count; o.empty = empty;
        o.full = full; o.ovf = ovf; o.unf = unf;
        return o;
    endfunction

    task automatic compare(input string nm, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got dout=%h count=%0d empty=%b full=%b ovf=%b unf=%b, expected dout=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                     nm, act.dout, act.count, act.empty, act.full, act.ovf, act.unf,
                     exp.dout, exp.count, exp.empty, exp.full, exp.ovf, exp.unf);
        end
    endtask

    // Apply one operation at the falling edge and queue the post-edge expectation.
    task automatic step(input string nm, input logic c, input logic pu, input logic po, input logic [7:0] d);
        @(negedge clk);
        clr = c; push = pu; pop = po; din = d;
        if (c) begin
            model.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pu && po) begin
            if (model.size() == 0) begin
                model.push_back(d);
                m_unf = 1'b1;
            end else begin
                model[model.size()-1] = d;
            end
        end else if (pu) begin
            if (model.size() == 4) m_ovf = 1'b1;
            else model.push_back(d);
        end else if (po) begin
            if (model.size() == 0) m_unf = 1'b1;
            else void'(model.pop_back());
        end
        exp_q.push_back(model_obs());
        name_q.push_back(nm);
    endtask

    // Monitor: compare DUT state just after every edge that has a pending expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                compare(name_q.pop_front(), dut_obs(), exp_q.pop_front());
            end
        end
    end

    initial begin
        obs_t zero;
        zero = '{dout: 8'h00, count: 3'd0, empty: 1'b1, full: 1'b0, ovf: 1'b0, unf: 1'b0};
        rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1 compare("reset_state", dut_obs(), zero);
        @(negedge clk);
        rst_n = 1'b1;

        step("push_11", 1'b0, 1'b1, 1'b0, 8'h11);
        step("push_22", 1'b0, 1'b1, 1'b0, 8'h22);
        step("push_33", 1'b0, 1'b1, 1'b0, 8'h33);
        for (int i = 0; i < 3; i++) step("pop_seq", 1'b0, 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 4; i++) step("fill_a", 1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
        step("push_full", 1'b0, 1'b1, 1'b0, 8'hFF);
        step("clr", 1'b1, 1'b0, 1'b0, 8'h00);

        step("push_10", 1'b0, 1'b1, 1'b0, 8'h10);
        step("push_20", 1'b0, 1'b1, 1'b0, 8'h20);
        step("repl_99", 1'b0, 1'b1, 1'b1, 8'h99);
        step("pop_after_repl", 1'b0, 1'b0, 1'b1, 8'h00);
        step("pop_to_empty", 1'b0, 1'b0, 1'b1, 8'h00);
        step("pop_empty", 1'b0, 1'b0, 1'b1, 8'h00);
        step("repl_empty_42", 1'b0, 1'b1, 1'b1, 8'h42);
        step("clr2", 1'b1, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset between edges with two entries held.
        step("pre_rst_a", 1'b0, 1'b1, 1'b0, 8'h5A);
        step("pre_rst_b", 1'b0, 1'b1, 1'b0, 8'hA5);
        step("idle", 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 compare("async_reset", dut_obs(), zero);
        model.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("push_after_rst", 1'b0, 1'b1, 1'b0, 8'h77);

        for (int i = 0; i < 600; i++) begin
            logic c, pu, po;
            c  = ($urandom_range(0, 29) == 0);
            pu = $urandom_range(0, 1);
            po = $urandom_range(0, 1);
            step("random", c, pu, po, 8'($urandom));
        end
        step("drain", 1'b0, 1'b0, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            errors++;
            $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/ret_addr_stack.md
# ret_addr_stack

Return-address stack for the RAT CPU. It pairs with the program counter:
- On CALL it captures the return address the PC supplies.
- On RET it drives the saved address back onto the PC load input.

The top of stack is presented combinationally, so the PC can load it on the same edge that pops it. The block sits in the control path between the control unit (PUSH/POP strobes) and the PC DIN mux.

## Interface
Parameters:
- n, 8, address width; matches the PC count width.
- DEPTH, 8, number of entries; power of two, at least 2.

Ports:
- CLK, input, 1, system clock; all state changes on the rising edge.
- RST_N, input, 1, reset; asynchronous, active-low.
- CLR, input, 1, synchronous flush; empties the stack and clears the error flags.
- PUSH, input, 1, CALL strobe; saves DIN.
- POP, input, 1, RET strobe; discards the top entry.
- DIN, input, n, return address to save (PC_COUNT + 1 from the PC path).
- DOUT, output, n, current top-of-stack entry; combinational; 0 when empty.
- COUNT, output, $clog2(DEPTH)+1, number of valid entries.
- EMPTY, output, 1, high when COUNT == 0.
- FULL, output, 1, high when COUNT == DEPTH.
- OVF, output, 1, sticky; set by a push while full.
- UNF, output, 1, sticky; set by a pop while empty.

## Operation
- Storage is DEPTH × n registers. Stack pointer SP equals COUNT.
- Write slot is mem[SP]. Top of stack is mem[SP-1].
- Priority each edge: CLR, then the PUSH/POP combinations below.
- CLR: SP←0, OVF←0, UNF←0. Memory contents are untouched.
- PUSH only, not full: mem[SP]←DIN, SP←SP+1.
- PUSH only, full: no write, SP unchanged, OVF←1.
- POP only, not empty: SP←SP−1.
- POP only, empty: SP stays 0, UNF←1.
- PUSH and POP, not empty: replace the top. mem[SP−1]←DIN, SP unchanged. This is valid even when full.
- PUSH and POP, empty: perform the push (mem[0]←DIN, SP←1) and set UNF←1.
- DOUT = EMPTY ? 0 : mem[SP−1]. It changes only after an SP or top-entry update, never mid-cycle from the strobes.
- OVF/UNF stay set until CLR or reset. They never block further operation.
- Address values are stored verbatim; no arithmetic is applied to DIN.

## Timing
- Reset (RST_N low, asynchronous): SP=0, EMPTY=1, FULL=0, COUNT=0, DOUT=0, OVF=0, UNF=0.
- Memory is not reset; stale contents are never visible because DOUT is masked while EMPTY.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Deassertion is synchronised by the system reset bridge; the block samples strobes from the first edge after release.
- Push latency: DIN is visible on DOUT after 1 edge. COUNT, FULL and EMPTY update on that same edge.
- Pop latency: 0 for the consumer. The DOUT value present before the edge is the return address. The PC asserts PC_LD with POP and captures DOUT on that edge.
- After a pop, DOUT shows the next-lower entry, or 0 if now empty.
- Flags are registered (derived from SP). No combinational path from PUSH/POP to any output.

## Structure
- Shared package rat_pkg holds:
  - the address-width constant (shared with the PC);
  - the default stack DEPTH;
  - a typedef for the stack-operation encoding {NOP, PUSH, POP, REPL}. The control unit uses the same encoding.
- The pointer/flag logic is in the top module.
- One sub-module, ras_regfile: a DEPTH × n register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata), no reset.
- The top derives waddr = REPL ? SP−1 : SP, and raddr = SP−1.

## Test plan
All scenarios use n=8, DEPTH=4.
- Reset, then PUSH 0x11, 0x22, 0x33 on consecutive edges → COUNT=3; DOUT=0x33 after the third edge; EMPTY=0, FULL=0.
- From there, POP three times → DOUT sequence 0x33→0x22→0x11→0x00, COUNT 2,1,0, EMPTY=1 after the third edge, UNF=0.
- Fill with 0xA0–0xA3, then PUSH 0xFF → FULL=1, COUNT=4, DOUT=0xA3, OVF=1. Then CLR → COUNT=0, OVF=0, DOUT=0.
- With stack {0x10,0x20}, PUSH+POP with DIN=0x99 → COUNT=2, DOUT=0x99. A following POP → DOUT=0x10.
- Empty stack: POP → UNF=1, COUNT=0. PUSH+POP with DIN=0x42 → COUNT=1, DOUT=0x42, UNF still 1.
- With 2 entries, drop RST_N between edges → COUNT=0, EMPTY=1, DOUT=0 before the next edge. A PUSH on the first edge after release succeeds.
